// File: rtl/demux_stage.sv
// Registered 1-to-N stream demultiplexer: one head register feeding N one-hot valid ports.
// Build option DEMUX_SKID_EN adds a one-entry skid buffer so in_ready is a pure register output.
module demux_stage #(
   parameter int WIDTH = 32,
   parameter int N_OUT = 2,
   parameter int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0] in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [N_OUT-1:0] out_valid,
   input  logic [N_OUT-1:0] out_ready,
   output logic [7:0]       drop_cnt
);

   // Handshake: a beat moves on a rising edge when valid && ready on that link;
   // valid never waits for ready, and a held beat stays stable until it moves.
   logic             head_valid;
   logic [SEL_W-1:0] head_sel;
   logic [WIDTH-1:0] head_data;

   logic head_fire;
   logic head_open;
   logic accept;
   logic in_range;
   logic push;

   always_comb begin
      out_valid = '0;
      for (int k = 0; k < N_OUT; k++) begin
         out_valid[k] = head_valid && (head_sel == SEL_W'(k));
      end
   end

   assign out_data  = head_data;
   assign head_fire = |(out_valid & out_ready);
   assign head_open = !head_valid || head_fire;
   assign accept    = in_valid && in_ready;
   assign in_range  = (32'(in_sel) < 32'(N_OUT));
   assign push      = accept && in_range;

`ifdef DEMUX_SKID_EN
   logic             skid_valid;
   logic [SEL_W-1:0] skid_sel;
   logic [WIDTH-1:0] skid_data;

   assign in_ready = !skid_valid;

   // A full skid blocks the input, so a skid-to-head move never races a new push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_valid <= 1'b0;
         head_sel   <= '0;
         head_data  <= '0;
         skid_valid <= 1'b0;
         skid_sel   <= '0;
         skid_data  <= '0;
      end else if (head_open) begin
         if (skid_valid) begin
            head_valid <= 1'b1;
            head_sel   <= skid_sel;
            head_data  <= skid_data;
            skid_valid <= 1'b0;
         end else if (push) begin
            head_valid <= 1'b1;
            head_sel   <= in_sel;
            head_data  <= in_data;
         end else begin
            head_valid <= 1'b0;
         end
      end else if (push) begin
         skid_valid <= 1'b1;
         skid_sel   <= in_sel;
         skid_data  <= in_data;
      end
   end
`else
   assign in_ready = head_open;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_valid <= 1'b0;
         head_sel   <= '0;
         head_data  <= '0;
      end else if (head_open) begin
         head_valid <= push;
         if (push) begin
            head_sel  <= in_sel;
            head_data <= in_data;
         end
      end
   end
`endif

   // Out-of-range beats are consumed here and never reach the head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (accept && !in_range && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end

endmodule
